process_close_ctrl: RTL
=======================

Name: process_close_ctrl

Overview:
- Parametrised successor to the CLOSE-packet handler in the UDT core.
- Accepts a CLOSE control packet on an AXI-Stream slave of configurable width, or a local close request. Drains the packet to tlast, then waits for the send and receive buffers to empty within a linger timeout.
- Reports CLOSING, then CLOSED (clean) or BROKEN (timeout), on a valid/ready state channel to the connection-state owner.

Parameters:
- DATA_W, 64, close stream data width in bits; multiple of 8, range 32..512.
- KEEP_W, DATA_W/8, tkeep width; derived, not overridden.
- LINGER_CYCLES, 1000000, max cycles in WAIT_BUF before BROKEN; 0 = wait forever.
- CNT_W, 32, linger counter width; must hold LINGER_CYCLES.

Ports:
- core_clk  in  1  core clock; all logic on rising edge.
- core_rst  in  1  synchronous reset, active-high.
- close_tvalid_i  in  1  CLOSE packet beat valid.
- close_tdata_i  in  DATA_W  CLOSE packet data; beat 0 bits[31:0] = peer socket ID.
- close_tkeep_i  in  KEEP_W  byte enables; accepted, not checked.
- close_tlast_i  in  1  last beat of packet.
- close_tready_o  out  1  beat accepted when tvalid&tready.
- close_req_i  in  1  single-cycle local close request.
- SND_BUFFER_EMPTY_i  in  1  send buffer empty (level).
- REV_BUFFER_EMPTY_i  in  1  receive buffer empty (level).
- udt_state_o  out  32  state code: 7 = CLOSING, 8 = CLOSED, 6 = BROKEN.
- state_valid_o  out  1  state code valid.
- state_ready_i  in  1  consumer accepts state.
- peer_close_o  out  1  1 = close initiated by peer packet, 0 = local.
- close_id_o  out  32  captured peer socket ID; 0 if local.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset values (sync, core_rst=1): FSM=IDLE, close_tready_o=0, state_valid_o=0, udt_state_o=0, peer_close_o=0, close_id_o=0, busy_o=0, linger counter=0. Reset mid-operation aborts any state; partially accepted packet beats are discarded.
- FSM states: IDLE, DRAIN, REP_CLOSING, WAIT_BUF, REP_FINAL, DONE.
- IDLE:
  - close_tready_o=1.
  - On accepted beat: capture tdata[31:0] to close_id_o, set peer_close_o=1. Go to REP_CLOSING if tlast, else DRAIN.
  - Else on close_req_i: peer_close_o=0, close_id_o=0, go to REP_CLOSING.
  - Same-cycle tvalid and close_req_i: peer packet wins; local request dropped.
- DRAIN: close_tready_o=1; beats consumed and discarded; on accepted tlast go to REP_CLOSING.
- REP_CLOSING:
  - Registered outputs: udt_state_o=7, state_valid_o=1 from the cycle after entry.
  - Hold until state_valid_o&state_ready_i, then drop valid next cycle and go to WAIT_BUF.
  - udt_state_o must not change while valid=1 and ready=0.
- WAIT_BUF:
  - Counter increments each cycle, starting at 0 on entry.
  - SND_BUFFER_EMPTY_i & REV_BUFFER_EMPTY_i both 1 -> REP_FINAL with code 8. If already empty on entry, transition after 1 cycle.
  - Else if LINGER_CYCLES != 0 and counter == LINGER_CYCLES-1 -> REP_FINAL with code 6.
  - Empty and timeout on the same cycle: empty wins, code 8.
  - Counter saturates, never wraps.
- REP_FINAL: same valid/ready rule as REP_CLOSING with the final code; on handshake go to DONE.
- DONE:
  - Terminal until reset. state_valid_o=0; udt_state_o holds the final code.
  - close_tready_o=1 so stray CLOSE beats are sunk; close_req_i is ignored.
- close_tready_o=0 in REP_CLOSING, WAIT_BUF, REP_FINAL; a peer packet arriving then stalls.
- busy_o=1 in every state except IDLE.
- Latency: packet tlast accepted at cycle t -> state_valid_o=1 (CLOSING) at t+1.

Test Plan:
- Single-beat close, tdata[31:0]=0x0000_ABCD, tlast=1, buffers empty, ready=1 -> CLOSING (7) at t+1, then CLOSED (8); close_id_o=0xABCD, peer_close_o=1, DONE.
- 4-beat close with tvalid gaps and DATA_W=128 -> all 4 beats accepted, tready=1 throughout; exactly one CLOSING report after beat 4.
- Local close_req_i pulse, SND_BUFFER_EMPTY_i held 0 for 50 cycles, LINGER_CYCLES=1000 -> CLOSING, then CLOSED 1 cycle after empty; peer_close_o=0, close_id_o=0.
- LINGER_CYCLES=16, buffers never empty -> BROKEN (6) valid exactly 16 cycles after WAIT_BUF entry. Repeat with empty asserted on cycle 16 -> CLOSED (8).
- state_ready_i held 0 for 10 cycles during each report -> valid and code stable, no state advance; proceeds on ready. Simultaneous close_req_i and tvalid -> peer path taken.
- core_rst asserted mid-DRAIN and mid-WAIT_BUF -> all outputs at reset values next cycle; a new close completes normally after reset.

Source files
------------

// File: rtl/process_close_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : process_close_ctrl
//  Purpose  : Connection close handler. Accepts a CLOSE control packet on an
//             AXI-Stream slave (or a local close request), drains the packet
//             to tlast, reports CLOSING, then waits for both buffers to empty
//             within a linger window and reports CLOSED (8) or BROKEN (6).
//  Ports    : core_clk/core_rst   - clock, synchronous active-high reset
//             close_t*            - CLOSE packet stream (slave side)
//             close_req_i         - single-cycle local close request
//             SND/REV_BUFFER_EMPTY_i - buffer empty levels
//             udt_state_o/state_valid_o/state_ready_i - state report channel
//             peer_close_o, close_id_o - close origin and peer socket ID
//             busy_o              - controller not idle
//  Revision : 1.0 - initial release
// ============================================================================
module process_close_ctrl #(
    parameter int DATA_W        = 64,
    parameter int KEEP_W        = DATA_W / 8,
    parameter int LINGER_CYCLES = 1000000,
    parameter int CNT_W         = 32
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              close_tvalid_i,
    input  logic [DATA_W-1:0] close_tdata_i,
    input  logic [KEEP_W-1:0] close_tkeep_i,
    input  logic              close_tlast_i,
    output logic              close_tready_o,
    input  logic              close_req_i,
    input  logic              SND_BUFFER_EMPTY_i,
    input  logic              REV_BUFFER_EMPTY_i,
    output logic [31:0]       udt_state_o,
    output logic              state_valid_o,
    input  logic              state_ready_i,
    output logic              peer_close_o,
    output logic [31:0]       close_id_o,
    output logic              busy_o
);

    localparam logic [31:0] c_code_closing = 32'd7;
    localparam logic [31:0] c_code_closed  = 32'd8;
    localparam logic [31:0] c_code_broken  = 32'd6;
    // Last counter value before timeout; meaningless (and unused) when the
    // linger window is disabled.
    localparam logic [CNT_W-1:0] c_linger_last =
        CNT_W'((LINGER_CYCLES == 0) ? 0 : LINGER_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_DRAIN       = 3'd1,
        S_REP_CLOSING = 3'd2,
        S_WAIT_BUF    = 3'd3,
        S_REP_FINAL   = 3'd4,
        S_DONE        = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_code;
    logic             r_valid;
    logic             r_peer;
    logic [31:0]      r_id;

    logic             w_tready;
    logic             w_beat;
    logic             w_handshake;
    logic             w_cap_peer;
    logic             w_cap_local;
    logic             w_rep_load;
    logic [31:0]      w_rep_code;
    logic             w_rep_clear;

    // Upper data bits and byte enables carry nothing this block needs.
    logic             w_unused_bits;
    assign w_unused_bits = ^{close_tkeep_i, close_tdata_i[DATA_W-1:32]};

    // Ready is held low while reset is applied so no beat is taken then.
    assign w_tready    = ~core_rst & ((r_state == S_IDLE) ||
                                      (r_state == S_DRAIN) ||
                                      (r_state == S_DONE));
    assign w_beat      = close_tvalid_i & w_tready;
    assign w_handshake = r_valid & state_ready_i;

    always_comb begin
        w_next      = r_state;
        w_cap_peer  = 1'b0;
        w_cap_local = 1'b0;
        w_rep_load  = 1'b0;
        w_rep_code  = c_code_closing;
        w_rep_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A peer beat takes priority over a same-cycle local request.
                if (w_beat) begin
                    w_cap_peer = 1'b1;
                    if (close_tlast_i) begin
                        w_next     = S_REP_CLOSING;
                        w_rep_load = 1'b1;
                    end else begin
                        w_next = S_DRAIN;
                    end
                end else if (close_req_i) begin
                    w_cap_local = 1'b1;
                    w_next      = S_REP_CLOSING;
                    w_rep_load  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_beat && close_tlast_i) begin
                    w_next     = S_REP_CLOSING;
                    w_rep_load = 1'b1;
                end
            end
            S_REP_CLOSING: begin
                if (w_handshake) begin
                    w_next      = S_WAIT_BUF;
                    w_rep_clear = 1'b1;
                end
            end
            S_WAIT_BUF: begin
                // Empty buffers win over a coincident timeout.
                if (SND_BUFFER_EMPTY_i && REV_BUFFER_EMPTY_i) begin
                    w_next     = S_REP_FINAL;
                    w_rep_load = 1'b1;
                    w_rep_code = c_code_closed;
                end else if ((LINGER_CYCLES != 0) && (r_cnt == c_linger_last)) begin
                    w_next     = S_REP_FINAL;
                    w_rep_load = 1'b1;
                    w_rep_code = c_code_broken;
                end
            end
            S_REP_FINAL: begin
                if (w_handshake) begin
                    w_next      = S_DONE;
                    w_rep_clear = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_DONE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_peer  <= 1'b0;
            r_id    <= '0;
        end else begin
            r_state <= w_next;

            // Counter is zero on WAIT_BUF entry and saturates at all-ones.
            if (r_state != S_WAIT_BUF) begin
                r_cnt <= '0;
            end else if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Code only changes on report entry, so it is stable while stalled.
            if (w_rep_load) begin
                r_code  <= w_rep_code;
                r_valid <= 1'b1;
            end else if (w_rep_clear) begin
                r_valid <= 1'b0;
            end

            if (w_cap_peer) begin
                r_peer <= 1'b1;
                r_id   <= close_tdata_i[31:0];
            end else if (w_cap_local) begin
                r_peer <= 1'b0;
                r_id   <= '0;
            end
        end
    end

    assign close_tready_o = w_tready;
    assign udt_state_o    = r_code;
    assign state_valid_o  = r_valid;
    assign peer_close_o   = r_peer;
    assign close_id_o     = r_id;
    assign busy_o         = (r_state != S_IDLE);

endmodule
`default_nettype wire
